// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data widths plus the decode/execute control bundle.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;
   typedef logic [3:0]  aluop_t;

   typedef struct packed {
      aluop_t     aluop;
      logic       aluSrc;
      logic       regWr;
      logic [1:0] regDst;
      logic       MemtoReg;
      logic       memWr;
      logic       beq;
      logic       bne;
      logic       j;
      logic       jr;
      logic       jal;
      logic       halt;
   } de_ctrl_t;

   localparam de_ctrl_t DE_CTRL_NOP = '0;

endpackage

// File: rtl/decode_execute_if.sv
// Bundle between decode/execute register, its consumer and a bench.
interface decode_execute_if;
   import cpu_types_pkg::*;

   logic     en, deif_stall, deif_flush, valid_in, valid_out, halt_out;
   word_t    pc4_in, rdat1_in, rdat2_in, imm_in;
   word_t    pc4_out, rdat1_out, rdat2_out, imm_out;
   regbits_t rs_in, rt_in, rd_in, deif_rs, deif_rt, deif_rd;
   de_ctrl_t ctrl_in, ctrl_out;
   logic     deif_MemtoReg, deif_memWr;
   word_t    bubble_cnt, stall_cnt;

   modport de (
      input  en, deif_stall, deif_flush, valid_in,
      input  pc4_in, rdat1_in, rdat2_in, imm_in,
      input  rs_in, rt_in, rd_in, ctrl_in,
      output valid_out, pc4_out, rdat1_out, rdat2_out, imm_out,
      output deif_rs, deif_rt, deif_rd, ctrl_out,
      output deif_MemtoReg, deif_memWr, halt_out, bubble_cnt, stall_cnt
   );

   modport ex (
      input valid_out, pc4_out, rdat1_out, rdat2_out, imm_out,
      input deif_rs, deif_rt, deif_rd, ctrl_out, halt_out
   );

   modport tb (
      output en, deif_stall, deif_flush, valid_in,
      output pc4_in, rdat1_in, rdat2_in, imm_in,
      output rs_in, rt_in, rd_in, ctrl_in,
      input  valid_out, pc4_out, rdat1_out, rdat2_out, imm_out,
      input  deif_rs, deif_rt, deif_rd, ctrl_out,
      input  deif_MemtoReg, deif_memWr, halt_out, bubble_cnt, stall_cnt
   );

endinterface

// File: rtl/de_perf_counter.sv
// 32-bit saturating event counter, cleared only by reset.
module de_perf_counter (
   input  logic        CLK,
   input  logic        RST,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         count <= '0;
      else if (inc && count != 32'hFFFF_FFFF)
         count <= count + 32'd1;
   end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode/execute pipeline register with stall, flush and halt freeze.
// Optional perf counters enabled by DE_PERF_CNT_EN.
module decode_execute_reg
   import cpu_types_pkg::*;
(
   input  logic     CLK,
   input  logic     RST,
   input  logic     en,
   input  logic     deif_stall,
   input  logic     deif_flush,
   input  logic     valid_in,
   input  word_t    pc4_in,
   input  word_t    rdat1_in,
   input  word_t    rdat2_in,
   input  word_t    imm_in,
   input  regbits_t rs_in,
   input  regbits_t rt_in,
   input  regbits_t rd_in,
   input  de_ctrl_t ctrl_in,
   output logic     valid_out,
   output word_t    pc4_out,
   output word_t    rdat1_out,
   output word_t    rdat2_out,
   output word_t    imm_out,
   output regbits_t deif_rs,
   output regbits_t deif_rt,
   output regbits_t deif_rd,
   output de_ctrl_t ctrl_out,
   output logic     deif_MemtoReg,
   output logic     deif_memWr,
   output logic     halt_out,
   output word_t    bubble_cnt,
   output word_t    stall_cnt
);

   de_ctrl_t ctrl_cap;

   // A non-valid slot never carries side effects downstream.
   assign ctrl_cap = valid_in ? ctrl_in : DE_CTRL_NOP;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST || deif_flush) begin
         valid_out <= 1'b0;
         pc4_out   <= '0;
         rdat1_out <= '0;
         rdat2_out <= '0;
         imm_out   <= '0;
         deif_rs   <= '0;
         deif_rt   <= '0;
         deif_rd   <= '0;
         ctrl_out  <= DE_CTRL_NOP;
         halt_out  <= 1'b0;
      end else if (!halt_out && !deif_stall && en) begin
         valid_out <= valid_in;
         pc4_out   <= pc4_in;
         rdat1_out <= rdat1_in;
         rdat2_out <= rdat2_in;
         imm_out   <= imm_in;
         deif_rs   <= rs_in;
         deif_rt   <= rt_in;
         deif_rd   <= rd_in;
         ctrl_out  <= ctrl_cap;
         halt_out  <= valid_in & ctrl_in.halt;
      end
   end

   assign deif_MemtoReg = ctrl_out.MemtoReg;
   assign deif_memWr    = ctrl_out.memWr;

`ifdef DE_PERF_CNT_EN
   logic stall_hit;

   assign stall_hit = deif_stall & ~deif_flush & ~halt_out;

   de_perf_counter u_bubble (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (deif_flush),
      .count (bubble_cnt)
   );

   de_perf_counter u_stall (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (stall_hit),
      .count (stall_cnt)
   );
`else
   assign bubble_cnt = '0;
   assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for decode_execute_reg; counter checks follow DE_PERF_CNT_EN.
module tb_decode_execute_reg;
   import cpu_types_pkg::*;

   logic     CLK = 1'b0;
   logic     RST;
   logic     en, deif_stall, deif_flush, valid_in;
   word_t    pc4_in, rdat1_in, rdat2_in, imm_in;
   regbits_t rs_in, rt_in, rd_in;
   de_ctrl_t ctrl_in;
   logic     valid_out, deif_MemtoReg, deif_memWr, halt_out;
   word_t    pc4_out, rdat1_out, rdat2_out, imm_out;
   regbits_t deif_rs, deif_rt, deif_rd;
   de_ctrl_t ctrl_out;
   word_t    bubble_cnt, stall_cnt;

   int total = 0;
   int fails = 0;
   de_ctrl_t c;

`ifdef DE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   always #5 CLK = ~CLK;

   decode_execute_reg dut (
      .CLK(CLK), .RST(RST), .en(en),
      .deif_stall(deif_stall), .deif_flush(deif_flush),
      .valid_in(valid_in), .pc4_in(pc4_in), .rdat1_in(rdat1_in),
      .rdat2_in(rdat2_in), .imm_in(imm_in), .rs_in(rs_in),
      .rt_in(rt_in), .rd_in(rd_in), .ctrl_in(ctrl_in),
      .valid_out(valid_out), .pc4_out(pc4_out),
      .rdat1_out(rdat1_out), .rdat2_out(rdat2_out),
      .imm_out(imm_out), .deif_rs(deif_rs), .deif_rt(deif_rt),
      .deif_rd(deif_rd), .ctrl_out(ctrl_out),
      .deif_MemtoReg(deif_MemtoReg), .deif_memWr(deif_memWr),
      .halt_out(halt_out), .bubble_cnt(bubble_cnt),
      .stall_cnt(stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive on the falling edge, then sample 1 time unit after the rise.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input word_t p, input word_t a,
                        input word_t b, input word_t im,
                        input regbits_t s, input regbits_t t,
                        input regbits_t d, input de_ctrl_t cc);
      @(negedge CLK);
      valid_in = v; pc4_in = p; rdat1_in = a; rdat2_in = b;
      imm_in = im; rs_in = s; rt_in = t; rd_in = d; ctrl_in = cc;
   endtask

   initial begin
      RST = 1'b1; en = 1'b0; deif_stall = 1'b0; deif_flush = 1'b0;
      valid_in = 1'b0; pc4_in = '0; rdat1_in = '0; rdat2_in = '0;
      imm_in = '0; rs_in = '0; rt_in = '0; rd_in = '0;
      ctrl_in = DE_CTRL_NOP;
      #3;
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_ctrl", 32'(ctrl_out), 32'd0);
      check("rst_pc4", pc4_out, 32'd0);
      check("rst_halt", 32'(halt_out), 32'd0);
      check("rst_bcnt", bubble_cnt, 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      // Basic load.
      c = DE_CTRL_NOP; c.regWr = 1'b1; c.memWr = 1'b1;
      drive(1, 32'h4, 32'hDEADBEEF, 32'h11, 32'h10, 3, 4, 5, c);
      en = 1'b1;
      tick();
      check("ld_rs", 32'(deif_rs), 32'd3);
      check("ld_rdat1", rdat1_out, 32'hDEADBEEF);
      check("ld_regwr", 32'(ctrl_out.regWr), 32'd1);
      check("ld_valid", 32'(valid_out), 32'd1);
      check("ld_memwr", 32'(deif_memWr), 32'd1);
      check("ld_rd", 32'(deif_rd), 32'd5);

      // Load-use stall for two edges with changing inputs.
      c = DE_CTRL_NOP; c.MemtoReg = 1'b1;
      drive(1, 32'h8, 32'h12345678, 32'h22, 32'h20, 7, 8, 9, c);
      deif_stall = 1'b1;
      tick();
      check("st1_rdat1", rdat1_out, 32'hDEADBEEF);
      check("st1_rs", 32'(deif_rs), 32'd3);
      drive(1, 32'hC, 32'hCAFEF00D, 32'h33, 32'h30, 10, 11, 12, c);
      tick();
      check("st2_pc4", pc4_out, 32'h4);
      check("st2_m2r", 32'(deif_MemtoReg), 32'd0);
      check("st_cnt", stall_cnt, PERF ? 32'd2 : 32'd0);

      // Stall and flush together: flush wins.
      @(negedge CLK);
      deif_flush = 1'b1;
      tick();
      check("sf_valid", 32'(valid_out), 32'd0);
      check("sf_ctrl", 32'(ctrl_out), 32'd0);
      check("sf_memwr", 32'(deif_memWr), 32'd0);
      check("sf_rdat1", rdat1_out, 32'd0);
      check("sf_bcnt", bubble_cnt, PERF ? 32'd1 : 32'd0);
      check("sf_scnt", stall_cnt, PERF ? 32'd2 : 32'd0);

      // Invalid slot: data captured, control forced to NOP.
      c = DE_CTRL_NOP; c.regWr = 1'b1; c.jal = 1'b1;
      drive(0, 32'h40, 32'h1, 32'h2, 32'hABCD, 1, 2, 3, c);
      deif_stall = 1'b0; deif_flush = 1'b0;
      tick();
      check("bub_valid", 32'(valid_out), 32'd0);
      check("bub_ctrl", 32'(ctrl_out), 32'd0);
      check("bub_imm", imm_out, 32'hABCD);

      // en low holds.
      drive(1, 32'h44, 32'h5, 32'h6, 32'h7, 4, 5, 6, c);
      en = 1'b0;
      tick();
      check("hold_imm", imm_out, 32'hABCD);
      check("hold_valid", 32'(valid_out), 32'd0);

      // Halt capture and freeze.
      c = DE_CTRL_NOP; c.halt = 1'b1;
      drive(1, 32'h100, 32'hAA, 32'hBB, 32'hCC, 1, 1, 1, c);
      en = 1'b1;
      tick();
      check("h_halt", 32'(halt_out), 32'd1);
      check("h_pc4", pc4_out, 32'h100);
      c = DE_CTRL_NOP; c.regWr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h200 + 32'(i), 32'h1, 32'h2, 32'h3, 2, 2, 2, c);
         tick();
      end
      check("hf_pc4", pc4_out, 32'h100);
      check("hf_halt", 32'(halt_out), 32'd1);
      check("hf_ctrl", 32'(ctrl_out.halt), 32'd1);
      @(negedge CLK);
      deif_stall = 1'b1;
      tick();
      check("hf_scnt", stall_cnt, PERF ? 32'd2 : 32'd0);
      @(negedge CLK);
      deif_stall = 1'b0; deif_flush = 1'b1;
      tick();
      check("hfl_halt", 32'(halt_out), 32'd0);
      check("hfl_valid", 32'(valid_out), 32'd0);
      check("hfl_bcnt", bubble_cnt, PERF ? 32'd2 : 32'd0);
      drive(1, 32'h300, 32'h77, 32'h88, 32'h99, 6, 7, 8, c);
      deif_flush = 1'b0;
      tick();
      check("resume_pc4", pc4_out, 32'h300);
      check("resume_valid", 32'(valid_out), 32'd1);

      // Asynchronous reset between edges.
      @(negedge CLK);
      #2;
      RST = 1'b1;
      #1;
      check("arst_pc4", pc4_out, 32'd0);
      check("arst_valid", 32'(valid_out), 32'd0);
      check("arst_ctrl", 32'(ctrl_out), 32'd0);
      check("arst_scnt", stall_cnt, 32'd0);
      #1;
      RST = 1'b0;
      tick();
      check("post_rst_pc4", pc4_out, 32'h300);
      check("post_rst_rs", 32'(deif_rs), 32'd6);

`ifdef DE_PERF_CNT_EN
      // Saturation: preload the bubble counter at its ceiling.
      @(negedge CLK);
      force dut.u_bubble.count = 32'hFFFF_FFFF;
      #1;
      release dut.u_bubble.count;
      deif_flush = 1'b1;
      tick();
      check("sat_bcnt", bubble_cnt, 32'hFFFF_FFFF);
      deif_flush = 1'b0;
`else
      @(negedge CLK);
      deif_flush = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      check("nocnt_bcnt", bubble_cnt, 32'd0);
      check("nocnt_valid", 32'(valid_out), 32'd0);
      deif_flush = 1'b0;
`endif

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
